// File: rtl/fifo_flagged.sv
// fifo_flagged: single-clock full-capacity FIFO with FWFT option, almost thresholds and sticky error flags
module fifo_flagged #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter bit FWFT = 0,
  parameter int ALMOST_FULL = 12,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic                     i_write,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_read,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_almost_empty,
  output logic                     o_almost_full,
  output logic [$clog2(DEPTH):0]   o_queued,
  output logic                     o_overflow,
  output logic                     o_underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rdata_q;
  logic wr_ok, rd_ok, busy;
  // the extra wrap bit lets occupancy reach DEPTH without sacrificing a slot
  assign o_queued       = wr_ptr - rd_ptr;
  assign o_empty        = o_queued == '0;
  assign o_full         = o_queued == PW'(DEPTH);
  assign o_almost_full  = o_queued >= PW'(ALMOST_FULL);
  assign o_almost_empty = o_queued <= PW'(ALMOST_EMPTY);
  assign busy           = !i_reset && !i_clear;
  assign wr_ok          = busy && i_write && !o_full;
  assign rd_ok          = busy && i_read && !o_empty;
  assign o_rdata        = FWFT ? mem[rd_ptr[AW-1:0]] : rdata_q;
  always_ff @(posedge i_clock)
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= i_wdata;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
      rdata_q     <= '0;
    end else if (i_clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (rd_ok) rdata_q <= mem[rd_ptr[AW-1:0]];
      if (i_write && o_full) o_overflow <= 1'b1;
      if (i_read && o_empty) o_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_flagged.sv
// tb_fifo_flagged: directed checks of a registered-read and an FWFT instance
module tb_fifo_flagged;
  logic clk = 0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic a_reset = 0, a_clear = 0, a_write = 0, a_read = 0;
  logic [7:0] a_wdata = 0, a_rdata;
  logic a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
  logic [2:0] a_queued;
  logic b_reset = 0, b_clear = 0, b_write = 0, b_read = 0;
  logic [7:0] b_wdata = 0, b_rdata;
  logic b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
  logic [2:0] b_queued;
  fifo_flagged #(.DEPTH(4), .WIDTH(8), .FWFT(0), .ALMOST_FULL(3), .ALMOST_EMPTY(1)) dut_a (
    .i_clock(clk), .i_reset(a_reset), .i_clear(a_clear), .i_write(a_write), .i_wdata(a_wdata),
    .i_read(a_read), .o_rdata(a_rdata), .o_empty(a_empty), .o_full(a_full),
    .o_almost_empty(a_ae), .o_almost_full(a_af), .o_queued(a_queued),
    .o_overflow(a_ovf), .o_underflow(a_unf));
  fifo_flagged #(.DEPTH(4), .WIDTH(8), .FWFT(1), .ALMOST_FULL(3), .ALMOST_EMPTY(1)) dut_b (
    .i_clock(clk), .i_reset(b_reset), .i_clear(b_clear), .i_write(b_write), .i_wdata(b_wdata),
    .i_read(b_read), .o_rdata(b_rdata), .o_empty(b_empty), .o_full(b_full),
    .o_almost_empty(b_ae), .o_almost_full(b_af), .o_queued(b_queued),
    .o_overflow(b_ovf), .o_underflow(b_unf));
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic a_op(input logic w, input logic [7:0] d, input logic r);
    a_write = w; a_wdata = d; a_read = r;
    tick();
    a_write = 0; a_read = 0;
  endtask
  task automatic a_clr();
    a_clear = 1; tick(); a_clear = 0;
  endtask
  initial begin
    a_reset = 1; b_reset = 1; tick(); a_reset = 0; b_reset = 0;
    chk("rst_queued", a_queued, 0); chk("rst_empty", a_empty, 1); chk("rst_full", a_full, 0);
    chk("rst_ae", a_ae, 1); chk("rst_af", a_af, 0); chk("rst_ovf", a_ovf, 0);
    chk("rst_unf", a_unf, 0); chk("rst_rdata", a_rdata, 0);
    for (int i = 0; i < 4; i++) begin
      a_op(1, 8'h11 * (i + 1), 0);
      chk("fill_queued", a_queued, i + 1);
      chk("fill_af", a_af, (i + 1) >= 3);
      chk("fill_ae", a_ae, (i + 1) <= 1);
      chk("fill_full", a_full, (i + 1) == 4);
    end
    a_op(1, 8'h55, 0);
    chk("ovf_queued", a_queued, 4); chk("ovf_flag", a_ovf, 1);
    for (int i = 0; i < 4; i++) begin
      a_op(0, 0, 1);
      chk("drain_rdata", a_rdata, 8'h11 * (i + 1));
      chk("drain_queued", a_queued, 3 - i);
    end
    chk("drain_empty", a_empty, 1);
    a_op(0, 0, 1);
    chk("unf_flag", a_unf, 1); chk("unf_rdata_hold", a_rdata, 8'h44); chk("ovf_sticky", a_ovf, 1);
    a_op(0, 0, 0);
    chk("unf_sticky", a_unf, 1);
    a_clr();
    chk("clr_ovf", a_ovf, 0); chk("clr_unf", a_unf, 0); chk("clr_rdata_kept", a_rdata, 8'h44);
    a_op(1, 8'hAA, 1);
    chk("sim_empty_queued", a_queued, 1); chk("sim_empty_unf", a_unf, 1);
    chk("sim_empty_rdata", a_rdata, 8'h44);
    a_clr();
    for (int i = 1; i <= 4; i++) a_op(1, 8'(i), 0);
    chk("sim_full_pre", a_full, 1);
    a_op(1, 8'hBB, 1);
    chk("sim_full_queued", a_queued, 3); chk("sim_full_ovf", a_ovf, 1); chk("sim_full_rdata", a_rdata, 1);
    for (int i = 2; i <= 4; i++) begin
      a_op(0, 0, 1);
      chk("sim_full_drain", a_rdata, i);
    end
    chk("sim_full_empty", a_empty, 1);
    a_op(1, 8'h05, 0); a_op(1, 8'h06, 0);
    a_op(1, 8'h07, 1);
    chk("sim_mid_queued", a_queued, 2); chk("sim_mid_rdata", a_rdata, 5);
    a_op(0, 0, 1); chk("sim_mid_r6", a_rdata, 6);
    a_op(0, 0, 1); chk("sim_mid_r7", a_rdata, 7); chk("sim_mid_empty", a_empty, 1);
    a_clr();
    for (int i = 0; i < 10; i++) begin
      a_op(1, 8'(i), 0);
      chk("wrap_queued_w", a_queued, 1);
      a_op(0, 0, 1);
      chk("wrap_rdata", a_rdata, i);
      chk("wrap_queued_r", a_queued, 0);
    end
    a_op(1, 8'h21, 0); a_op(1, 8'h22, 0);
    a_write = 1; a_read = 1; a_wdata = 8'h99; a_clear = 1; tick();
    a_write = 0; a_read = 0; a_clear = 0;
    chk("clr_ignore_queued", a_queued, 0); chk("clr_ignore_ovf", a_ovf, 0);
    chk("clr_ignore_unf", a_unf, 0); chk("clr_ignore_rdata", a_rdata, 9);
    for (int i = 1; i <= 4; i++) a_op(1, 8'(8'h30 + i), 0);
    a_op(1, 8'h77, 0);
    a_op(0, 0, 1);
    chk("mid_pre_queued", a_queued, 3); chk("mid_pre_ovf", a_ovf, 1); chk("mid_pre_rdata", a_rdata, 8'h31);
    a_reset = 1; a_write = 1; a_wdata = 8'hEE; tick(); a_reset = 0; a_write = 0;
    chk("mid_rst_queued", a_queued, 0); chk("mid_rst_empty", a_empty, 1);
    chk("mid_rst_ovf", a_ovf, 0); chk("mid_rst_unf", a_unf, 0); chk("mid_rst_rdata", a_rdata, 0);
    chk("fw_rst_empty", b_empty, 1);
    b_write = 1; b_wdata = 8'h5A; tick(); b_write = 0;
    chk("fw_empty_after_w", b_empty, 0); chk("fw_rdata_5a", b_rdata, 8'h5A);
    tick();
    chk("fw_rdata_hold", b_rdata, 8'h5A);
    b_read = 1; tick(); b_read = 0;
    chk("fw_empty_after_r", b_empty, 1);
    b_write = 1; b_wdata = 8'h01; tick(); b_wdata = 8'h02; tick(); b_write = 0;
    chk("fw_head_01", b_rdata, 8'h01); chk("fw_queued2", b_queued, 2);
    b_read = 1; tick();
    chk("fw_head_02", b_rdata, 8'h02);
    tick(); b_read = 0;
    chk("fw_drained", b_empty, 1); chk("fw_unf", b_unf, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
